// File: rtl/pwm_precond_pkg.sv
// Shared types and constants for the PWM edge preconditioner.
package pwm_precond_pkg;

    localparam int unsigned DEF_WIDTH    = 13;
    localparam int unsigned DEF_DEPTH    = 249;
    localparam int unsigned DRAIN_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        COMMIT
    } state_t;

    // Rise/fall edge pair for one transducer.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] rise;
        logic [DEF_WIDTH-1:0] fall;
    } edge_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_precond_if.sv
// Silencer-to-preconditioner bus: strobe, filtered arrays in, PWM edges out.
interface pwm_precond_if
    import pwm_precond_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) ();

    logic                         done_in;
    logic [DEPTH-1:0][WIDTH-1:0]  cycle;
    logic [DEPTH-1:0][WIDTH-1:0]  duty_s;
    logic [DEPTH-1:0][WIDTH-1:0]  phase_s;
    logic [DEPTH-1:0][WIDTH-1:0]  rise;
    logic [DEPTH-1:0][WIDTH-1:0]  fall;
    logic                         done_out;
    logic                         busy;

    modport master (
        output done_in, cycle, duty_s, phase_s,
        input  rise, fall, done_out, busy
    );

    modport slave (
        input  done_in, cycle, duty_s, phase_s,
        output rise, fall, done_out, busy
    );

endinterface

// File: rtl/pwm_precond_calc.sv
// Two-stage duty/phase to rise/fall converter for one transducer per cycle.
// Optional feature: PWM_PRECOND_DUTY_CLAMP_EN maps D >= C to always-high.
module pwm_precond_calc
    import pwm_precond_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] p,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output edge_t            out_edge
);

    localparam int unsigned XW = WIDTH + 1;

    // Odd duty: the extra count lands on the fall side via the ceil half.
    logic [WIDTH-1:0] half_c;
    logic [WIDTH-1:0] upper_c;
    logic [XW-1:0]    diff_c;
    logic [XW-1:0]    sum_c;

    assign half_c  = d >> 1;
    assign upper_c = d - half_c;
    assign diff_c  = XW'(p) - XW'(half_c);
    assign sum_c   = XW'(p) + XW'(upper_c);

    logic             s1_valid;
    logic [IDX_W-1:0] s1_idx;
    logic [WIDTH-1:0] s1_c;
    logic [XW-1:0]    s1_diff;
    logic [XW-1:0]    s1_sum;
    logic             s1_zero;
`ifdef PWM_PRECOND_DUTY_CLAMP_EN
    logic             s1_clamp;
`endif

    // Stage 1: half duty, raw rise/fall sums and special-case flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_c     <= '0;
            s1_diff  <= '0;
            s1_sum   <= '0;
            s1_zero  <= 1'b0;
`ifdef PWM_PRECOND_DUTY_CLAMP_EN
            s1_clamp <= 1'b0;
`endif
        end else begin
            s1_valid <= in_valid;
            s1_idx   <= in_idx;
            s1_c     <= c;
            s1_diff  <= diff_c;
            s1_sum   <= sum_c;
            s1_zero  <= (d == '0);
`ifdef PWM_PRECOND_DUTY_CLAMP_EN
            s1_clamp <= (d >= c);
`endif
        end
    end

    logic [XW-1:0]    rise_wrap_c;
    logic [XW-1:0]    fall_wrap_c;
    logic [WIDTH-1:0] rise_c;
    logic [WIDTH-1:0] fall_c;

    // Stage 2 combinational: single conditional wrap, then special duties.
    always_comb begin
        rise_wrap_c = s1_diff[WIDTH] ? (s1_diff + XW'(s1_c)) : s1_diff;
        fall_wrap_c = (s1_sum >= XW'(s1_c)) ? (s1_sum - XW'(s1_c)) : s1_sum;
        rise_c      = WIDTH'(rise_wrap_c);
        fall_c      = WIDTH'(fall_wrap_c);
        if (s1_zero) begin
            rise_c = '0;
            fall_c = '0;
        end
`ifdef PWM_PRECOND_DUTY_CLAMP_EN
        else if (s1_clamp) begin
            // fall == C never matches the carrier counter: output stays high.
            rise_c = '0;
            fall_c = s1_c;
        end
`endif
    end

    // Stage 2 register: result handed to the shadow array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_edge  <= '0;
        end else begin
            out_valid     <= s1_valid;
            out_idx       <= s1_idx;
            out_edge.rise <= rise_c;
            out_edge.fall <= fall_c;
        end
    end

endmodule

// File: rtl/pwm_precond.sv
// PWM preconditioner top: sequences the transducer walk, buffers results
// in a shadow array and commits all edges to the PWM generators at once.
module pwm_precond
    import pwm_precond_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    pwm_precond_if.slave  bus
);

    localparam int unsigned          IDX_W      = idx_width(DEPTH);
    localparam int unsigned          DRAIN_W    = idx_width(DRAIN_CYCLES);
    localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(DEPTH - 1);
    localparam logic [DRAIN_W-1:0]   LAST_DRAIN = DRAIN_W'(DRAIN_CYCLES - 1);

    state_t                      state_q;
    logic [IDX_W-1:0]            idx_q;
    logic [DRAIN_W-1:0]          drain_q;
    logic                        pending_q;
    logic                        busy_q;
    logic                        done_out_q;
    logic [DEPTH-1:0][WIDTH-1:0] rise_q;
    logic [DEPTH-1:0][WIDTH-1:0] fall_q;
    edge_t                       shadow_q [DEPTH];

    logic [WIDTH-1:0]            cyc_c;
    logic [WIDTH-1:0]            duty_c;
    logic [WIDTH-1:0]            phase_c;
    logic                        issue_c;
    logic                        calc_valid;
    logic [IDX_W-1:0]            calc_idx;
    edge_t                       calc_edge;

    // Inputs are read live at the issued index.
    assign cyc_c   = bus.cycle[idx_q];
    assign duty_c  = bus.duty_s[idx_q];
    assign phase_c = bus.phase_s[idx_q];
    assign issue_c = (state_q == RUN);

    pwm_precond_calc #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_calc (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (issue_c),
        .in_idx    (idx_q),
        .c         (cyc_c),
        .d         (duty_c),
        .p         (phase_c),
        .out_valid (calc_valid),
        .out_idx   (calc_idx),
        .out_edge  (calc_edge)
    );

    // Shadow array: collects results until the commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (calc_valid) begin
            shadow_q[calc_idx] <= calc_edge;
        end
    end

    // Sequencer: trigger/pending handling, index walk, drain and commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            drain_q    <= '0;
            pending_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_out_q <= 1'b0;
            rise_q     <= '0;
            fall_q     <= '0;
        end else begin
            done_out_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.done_in || pending_q) begin
                        state_q   <= RUN;
                        idx_q     <= '0;
                        pending_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.done_in) begin
                        pending_q <= 1'b1;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_q <= DRAIN;
                        drain_q <= '0;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DRAIN: begin
                    if (bus.done_in) begin
                        pending_q <= 1'b1;
                    end
                    if (drain_q == LAST_DRAIN) begin
                        state_q <= COMMIT;
                    end else begin
                        drain_q <= drain_q + DRAIN_W'(1);
                    end
                end
                COMMIT: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        rise_q[i] <= WIDTH'(shadow_q[i].rise);
                        fall_q[i] <= WIDTH'(shadow_q[i].fall);
                    end
                    done_out_q <= 1'b1;
                    idx_q      <= '0;
                    // A strobe landing on this cycle is kept for the next pass.
                    pending_q  <= bus.done_in;
                    if (pending_q) begin
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.rise     = rise_q;
    assign bus.fall     = fall_q;
    assign bus.done_out = done_out_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_pwm_precond.sv
// Directed bench for pwm_precond: conversion values, latency, atomic commit,
// re-trigger through pending, and asynchronous reset mid-run.
module tb_pwm_precond;

    localparam int unsigned WIDTH = 13;
    localparam int unsigned DEPTH = 249;
    localparam int          LAT   = DEPTH + 3;

    logic clk;
    logic rst_n;

    int checks;
    int passes;

    pwm_precond_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    pwm_precond #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int c;
        int d;
        int p;
        int er;
        int ef;
    } vec_t;

    vec_t vt[$];
    int   exp_r [DEPTH];
    int   exp_f [DEPTH];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic fill(input int c, input int d, input int p);
        for (int i = 0; i < DEPTH; i++) begin
            bus.cycle[i]   = WIDTH'(c);
            bus.duty_s[i]  = WIDTH'(d);
            bus.phase_s[i] = WIDTH'(p);
        end
    endtask

    task automatic set_exp(input int r, input int f);
        for (int i = 0; i < DEPTH; i++) begin
            exp_r[i] = r;
            exp_f[i] = f;
        end
    endtask

    task automatic check_all(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.rise[i] !== WIDTH'(exp_r[i]) || bus.fall[i] !== WIDTH'(exp_f[i])) bad++;
        end
        chk(tag, bad, 0);
    endtask

    // Strobe once, wait for the commit, verify latency and that outputs held.
    task automatic run_conv(input string tag);
        logic [DEPTH-1:0][WIDTH-1:0] r0;
        logic [DEPTH-1:0][WIDTH-1:0] f0;
        int lat;
        bit stable;
        r0 = bus.rise;
        f0 = bus.fall;
        lat = -1;
        stable = 1'b1;
        bus.done_in = 1'b1;
        step();
        bus.done_in = 1'b0;
        chk({tag, "_busy_rise"}, bus.busy, 1);
        for (int k = 1; k <= 400 && lat < 0; k++) begin
            step();
            if (bus.done_out === 1'b1) lat = k;
            else if (bus.rise !== r0 || bus.fall !== f0) stable = 1'b0;
        end
        chk({tag, "_latency"}, lat, LAT);
        chk({tag, "_held_until_commit"}, stable, 1);
        check_all({tag, "_all_edges"});
    endtask

    initial begin
        int npulse;
        int p1;
        int p2;
        int late;

        checks = 0;
        passes = 0;
        rst_n = 1'b0;
        bus.done_in = 1'b0;
        fill(4096, 2048, 1024);

        // Reset state
        step();
        step();
        chk("rst_busy", bus.busy, 0);
        chk("rst_done_out", bus.done_out, 0);
        chk("rst_rise0", bus.rise[0], 0);
        chk("rst_fall_last", bus.fall[DEPTH-1], 0);
        rst_n = 1'b1;
        step();

        // Basic: 0 / 2048 everywhere
        set_exp(0, 2048);
        run_conv("basic");
        chk("basic_rise5", bus.rise[5], 0);
        chk("basic_fall5", bus.fall[5], 2048);
        step();
        chk("basic_done_one_cycle", bus.done_out, 0);
        chk("basic_busy_low", bus.busy, 0);

        // Directed per-index vectors on top of the basic background
        vt.push_back(vec_t'{0,   4096, 2048, 0,    3072, 1024});
        vt.push_back(vec_t'{1,   4096, 3,    100,  99,   102});
        vt.push_back(vec_t'{2,   4096, 0,    500,  0,    0});
        vt.push_back(vec_t'{3,   1000, 999,  999,  500,  499});
        vt.push_back(vec_t'{4,   2,    1,    1,    1,    0});
        vt.push_back(vec_t'{5,   8191, 8190, 0,    4096, 4095});
        vt.push_back(vec_t'{7,   4096, 1,    0,    0,    1});
        vt.push_back(vec_t'{248, 4096, 100,  4095, 4045, 49});
`ifdef PWM_PRECOND_DUTY_CLAMP_EN
        vt.push_back(vec_t'{6,   4096, 5000, 10,   0,    4096});
`endif
        set_exp(0, 2048);
        foreach (vt[n]) begin
            bus.cycle[vt[n].idx]   = WIDTH'(vt[n].c);
            bus.duty_s[vt[n].idx]  = WIDTH'(vt[n].d);
            bus.phase_s[vt[n].idx] = WIDTH'(vt[n].p);
            exp_r[vt[n].idx] = vt[n].er;
            exp_f[vt[n].idx] = vt[n].ef;
        end
        run_conv("vec");
        foreach (vt[n]) begin
            chk($sformatf("vec_rise_idx%0d", vt[n].idx), bus.rise[vt[n].idx], vt[n].er);
            chk($sformatf("vec_fall_idx%0d", vt[n].idx), bus.fall[vt[n].idx], vt[n].ef);
        end
        step();

        // Re-trigger: strobes at t0, t0+10, t0+20 -> two commits
        fill(4096, 1000, 2000);
        npulse = 0;
        p1 = -1;
        p2 = -1;
        bus.done_in = 1'b1;
        step();
        for (int k = 1; k <= 600; k++) begin
            bus.done_in = (k == 10 || k == 20);
            step();
            if (bus.done_out === 1'b1) begin
                npulse++;
                if (npulse == 1) begin
                    p1 = k;
                    set_exp(1500, 2500);
                    check_all("retrig_first_values");
                    fill(4096, 2000, 10);
                end else if (npulse == 2) begin
                    p2 = k;
                    set_exp(3106, 1010);
                    check_all("retrig_second_values");
                end
            end
        end
        bus.done_in = 1'b0;
        chk("retrig_pulse_count", npulse, 2);
        chk("retrig_first_at", p1, LAT);
        chk("retrig_second_at", p2, 2 * LAT);
        chk("retrig_busy_low", bus.busy, 0);

        // Reset mid-run: abort, outputs cleared immediately, no commit
        fill(4096, 500, 300);
        bus.done_in = 1'b1;
        step();
        bus.done_in = 1'b0;
        for (int k = 1; k < 100; k++) step();
        rst_n = 1'b0;
        #2;
        chk("midrst_rise0", bus.rise[0], 0);
        chk("midrst_fall0", bus.fall[0], 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done_out", bus.done_out, 0);
        step();
        step();
        rst_n = 1'b1;
        late = 0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (bus.done_out !== 1'b0) late++;
        end
        chk("midrst_no_done", late, 0);
        chk("midrst_fall_stays0", bus.fall[10], 0);
        set_exp(50, 550);
        run_conv("post_rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
